mem_block_mover: RTL and testbench
==================================

# mem_block_mover

Initiator-side engine for the single-port data memory: drives its address, write-enable and write-data lines and consumes its combinational read data to perform block copy and block fill of 32-bit words without processor involvement. Sits between the CPU control path, which issues one command via a start/busy/done handshake, and the data memory port, which it owns while busy.

## Interface
Parameters:
- CNT_W, 16, width of the word-count operand; maximum block is 2^CNT_W−1 words.

Ports:
- clk  in  1  rising-edge clock shared with the data memory.
- reset  in  1  synchronous, active-high reset.
- start  in  1  command strobe; sampled only in IDLE.
- mode  in  1  0 = copy, 1 = fill; captured with start.
- src  in  32  copy: source byte address; fill: the 32-bit fill value.
- dst  in  32  destination byte address.
- count  in  CNT_W  number of words to transfer.
- busy  out  1  high from the cycle after accepted start until DONE.
- done  out  1  one-cycle pulse on completion.
- checksum  out  32  wrapping sum of all words written by the last command.
- memAddress  out  32  byte address to the memory.
- memWriteEnable  out  1  memory write strobe; the write commits at the next clk edge.
- memDataIn  out  32  write data to the memory.
- memDataOut  in  32  combinational read data from the memory, same cycle as memAddress.

## Operation
- States: IDLE, READ, WRITE, DONE. Outputs decode from registered state and pointers only.
- IDLE: all memory outputs 0, busy 0. When start=1, capture mode, src/dst with bits [1:0] forced to 0 (fill value captured unmodified), and count. Clear checksum. Go to READ for copy, WRITE for fill, or DONE if count=0.
- READ: memAddress=src_ptr, memWriteEnable=0. At the edge, latch memDataOut into the word buffer and go to WRITE.
- WRITE: memAddress=dst_ptr, memDataIn=buffer (fill: the fill value), memWriteEnable=1. At the edge: dst_ptr+=4, src_ptr+=4 (copy only), remaining−=1, checksum+=memDataIn. If remaining was 1, go to DONE; otherwise copy goes to READ and fill stays in WRITE.
- DONE: done=1, busy=0, memWriteEnable=0. Always returns to IDLE next cycle.
- start outside IDLE is ignored. Operand changes after capture have no effect.
- Pointer arithmetic is modulo 2^32. Wrap from 0xFFFFFFFC to 0 is legal and is not flagged.
- Copy is forward-only. When dst is greater than src and the regions overlap, the copy propagates already-written words. This is the defined behaviour.
- reset in any state: next cycle is IDLE, all outputs 0. An interrupted write does not commit unless its edge coincides with reset deassertion; reset has priority, so no write occurs on the reset edge.

## Timing
- Reset values: busy 0, done 0, checksum 0, memAddress 0, memWriteEnable 0, memDataIn 0.
- Copy of N words: 2N cycles in READ/WRITE plus 1 DONE cycle. done asserts 2N+1 cycles after the start edge.
- Fill of N words: N WRITE cycles plus DONE. done asserts N+1 cycles after the start edge.
- count=0: done asserts 1 cycle after the start edge, with no memory write.
- start can be re-asserted in the cycle after done, i.e. the first IDLE cycle.

## Configuration
- MEM_BLOCK_MOVER_CHECKSUM_EN defined: the checksum accumulator is built, and checksum holds a valid value from DONE until the next accepted start.
- MEM_BLOCK_MOVER_CHECKSUM_EN undefined: no accumulator is built and checksum is tied to 0. All other behaviour and timing are identical.

## Test plan
- Copy: preload words 0x11,0x22,0x33 at 0x100..0x108. start mode=0, src=0x100, dst=0x200, count=3 -> memory 0x200..0x208 = 0x11,0x22,0x33; done 7 cycles after start; checksum=0x66 (0 without macro).
- Fill: src=0xDEADBEEF, dst=0x40, count=4 -> 0x40..0x4C all 0xDEADBEEF; memWriteEnable high exactly 4 consecutive cycles; done at cycle 5.
- count=0 with dst=0x80 -> memWriteEnable never asserts; done pulses 1 cycle after start; 0x80 unchanged.
- Misaligned and busy: dst=0x203 -> writes land at 0x200. A second start pulse while busy -> ignored; command count unchanged.
- Reset mid-copy: count=8, assert reset in the 5th cycle -> IDLE next cycle with all outputs 0; only the first 2 words written; no done pulse.
- Overlap and wrap: memory 0x100=A, 0x104=B; copy src=0x100, dst=0x104, count=2 -> 0x104=A, 0x108=A. Fill dst=0xFFFFFFFC, count=2 -> second memAddress = 0x00000000.

Source files
------------

// File: rtl/mem_block_mover.sv
// mem_block_mover
// ----------------
// DMA-style block copy / block fill engine for a single-port data memory
// with combinational read data. The CPU issues one command through a
// start/busy/done handshake. While busy, this engine owns the memory port.
//
// Copy moves one word every two cycles: READ latches the word, WRITE stores it.
// Fill writes one word per cycle.
//
// Optional feature macro: MEM_BLOCK_MOVER_CHECKSUM_EN
//   defined   -> a wrapping 32-bit sum of all written words is accumulated.
//   undefined -> checksum is tied to 0.
//
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   start, mode                command strobe (IDLE only); 0 = copy, 1 = fill
//   src, dst, count            source address or fill value, destination, word count
//   busy, done                 engine active / one-cycle completion pulse
//   checksum                   sum of words written by the last command
//   memAddress, memWriteEnable,
//   memDataIn                  memory request (byte address, write strobe, write data)
//   memDataOut                 combinational read data from memory

module mem_block_mover #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             mode,
    input  logic [31:0]      src,
    input  logic [31:0]      dst,
    input  logic [CNT_W-1:0] count,
    output logic             busy,
    output logic             done,
    output logic [31:0]      checksum,
    output logic [31:0]      memAddress,
    output logic             memWriteEnable,
    output logic [31:0]      memDataIn,
    input  logic [31:0]      memDataOut
);

    typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

    state_t             state_reg, state_next;
    logic               fill_reg;
    logic [31:0]        src_reg;        // source pointer (copy) or fill value (fill)
    logic [31:0]        dst_reg;
    logic [CNT_W-1:0]   remaining_reg;
    logic [31:0]        buffer_reg;

    always_ff @(posedge clk) begin
        if (reset) state_reg <= IDLE;
        else       state_reg <= state_next;
    end

    always_comb begin
        state_next     = state_reg;
        busy           = 1'b0;
        done           = 1'b0;
        memAddress     = 32'h0;
        memWriteEnable = 1'b0;
        memDataIn      = 32'h0;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    if (count == '0) state_next = DONE;
                    else if (mode)   state_next = WRITE;
                    else             state_next = READ;
                end
            end
            READ: begin
                busy       = 1'b1;
                memAddress = src_reg;
                state_next = WRITE;
            end
            WRITE: begin
                busy           = 1'b1;
                memAddress     = dst_reg;
                memDataIn      = fill_reg ? src_reg : buffer_reg;
                // Reset wins over a write landing on the same edge.
                memWriteEnable = ~reset;
                if (remaining_reg == CNT_W'(1)) state_next = DONE;
                else if (fill_reg)              state_next = WRITE;
                else                            state_next = READ;
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fill_reg      <= 1'b0;
            src_reg       <= 32'h0;
            dst_reg       <= 32'h0;
            remaining_reg <= '0;
            buffer_reg    <= 32'h0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        fill_reg      <= mode;
                        // The fill value is data, not an address: keep all its bits.
                        src_reg       <= mode ? src : (src & ~32'h3);
                        dst_reg       <= dst & ~32'h3;
                        remaining_reg <= count;
                    end
                end
                READ: buffer_reg <= memDataOut;
                WRITE: begin
                    dst_reg       <= dst_reg + 32'd4;
                    if (!fill_reg) src_reg <= src_reg + 32'd4;
                    remaining_reg <= remaining_reg - CNT_W'(1);
                end
                default: ;
            endcase
        end
    end

`ifdef MEM_BLOCK_MOVER_CHECKSUM_EN
    logic [31:0] checksum_reg;

    always_ff @(posedge clk) begin
        if (reset)
            checksum_reg <= 32'h0;
        else if (state_reg == IDLE && start)
            checksum_reg <= 32'h0;
        else if (state_reg == WRITE)
            checksum_reg <= checksum_reg + memDataIn;
    end

    assign checksum = checksum_reg;
`else
    assign checksum = 32'h0;
`endif

endmodule

// File: tb/tb_mem_block_mover.sv
// Directed bench for mem_block_mover with a 256-word behavioural memory.
// The memory uses combinational reads and decodes address bits [9:2].
module tb_mem_block_mover;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        mode = 1'b0;
    logic [31:0] src = '0, dst = '0;
    logic [15:0] count = '0;
    logic        busy, done, memWriteEnable;
    logic [31:0] checksum, memAddress, memDataIn, memDataOut;

    mem_block_mover #(.CNT_W(16)) dut (
        .clk(clk), .reset(reset), .start(start), .mode(mode),
        .src(src), .dst(dst), .count(count),
        .busy(busy), .done(done), .checksum(checksum),
        .memAddress(memAddress), .memWriteEnable(memWriteEnable),
        .memDataIn(memDataIn), .memDataOut(memDataOut)
    );

    always #5 clk = ~clk;

    // Behavioural memory; bench preloads go through pre_we so one process owns it.
    logic [31:0] mem [0:255];
    logic        tb_init = 1'b1;
    logic        pre_we = 1'b0;
    logic [7:0]  pre_idx = '0;
    logic [31:0] pre_data = '0;

    assign memDataOut = mem[memAddress[9:2]];

    always @(posedge clk) begin
        if (tb_init) begin
            for (int k = 0; k < 256; k++) mem[k] <= 32'hA000_0000 + k;
        end else if (memWriteEnable) begin
            mem[memAddress[9:2]] <= memDataIn;
        end else if (pre_we) begin
            mem[pre_idx] <= pre_data;
        end
    end

    int nvec = 0;
    int nerr = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic preload(input logic [31:0] addr, input logic [31:0] data);
        @(negedge clk);
        pre_we = 1'b1; pre_idx = addr[9:2]; pre_data = data;
        @(negedge clk);
        pre_we = 1'b0;
    endtask

    // Results of the last command
    int          lat, nwr, first_we, last_we;
    logic        busy1, busy_at_done;
    logic [31:0] wa [$];

    // Start a command. Cycle i is counted from the start edge, so i = 1 is the
    // first cycle after it. poke: re-pulse start with other operands in that cycle.
    // rst_at: raise reset in that cycle.
    task automatic run_cmd(input logic m, input logic [31:0] s, input logic [31:0] d,
                           input logic [15:0] c, input int poke, input int rst_at);
        lat = 0; nwr = 0; first_we = -1; last_we = -1;
        busy1 = 1'b0; busy_at_done = 1'b1;
        wa.delete();
        @(negedge clk);
        start = 1'b1; mode = m; src = s; dst = d; count = c;
        for (int i = 1; i <= 60; i++) begin
            @(negedge clk);
            start = (i == poke);
            if (i == poke) begin
                mode = ~m; src = 32'h0; dst = 32'h3F0; count = 16'd5;
            end
            if (memWriteEnable) begin
                nwr++;
                wa.push_back(memAddress);
                if (first_we < 0) first_we = i;
                last_we = i;
            end
            if (i == 1) busy1 = busy;
            if (done) begin
                lat = i;
                busy_at_done = busy;
                break;
            end
            if (rst_at > 0 && i == rst_at) reset = 1'b1;
            if (rst_at > 0 && i == rst_at + 1) begin
                check_eq("rst_busy", {31'h0, busy}, 32'h0);
                check_eq("rst_done", {31'h0, done}, 32'h0);
                check_eq("rst_addr", memAddress, 32'h0);
                check_eq("rst_we", {31'h0, memWriteEnable}, 32'h0);
                check_eq("rst_wdata", memDataIn, 32'h0);
                check_eq("rst_csum", checksum, 32'h0);
                reset = 1'b0;
            end
            if (rst_at > 0 && i > rst_at + 6) break;
        end
        start = 1'b0;
    endtask

    logic [31:0] exp_csum;

    initial begin
        repeat (3) @(negedge clk);
        tb_init = 1'b0;
        reset = 1'b0;
        @(negedge clk);
        check_eq("reset_busy", {31'h0, busy}, 32'h0);
        check_eq("reset_done", {31'h0, done}, 32'h0);
        check_eq("reset_csum", checksum, 32'h0);
        check_eq("reset_addr", memAddress, 32'h0);
        check_eq("reset_we", {31'h0, memWriteEnable}, 32'h0);
        check_eq("reset_wdata", memDataIn, 32'h0);

        // Copy of 3 words
        preload(32'h100, 32'h11);
        preload(32'h104, 32'h22);
        preload(32'h108, 32'h33);
        run_cmd(1'b0, 32'h100, 32'h200, 16'd3, 0, 0);
        $display("copy 0x100->0x200 n=3: latency %0d, writes %0d", lat, nwr);
        check_eq("copy_lat", lat, 7);
        check_eq("copy_nwr", nwr, 3);
        check_eq("copy_busy1", {31'h0, busy1}, 32'h1);
        check_eq("copy_busy_done", {31'h0, busy_at_done}, 32'h0);
        @(negedge clk);
        check_eq("copy_m200", mem[8'h80], 32'h11);
        check_eq("copy_m204", mem[8'h81], 32'h22);
        check_eq("copy_m208", mem[8'h82], 32'h33);
`ifdef MEM_BLOCK_MOVER_CHECKSUM_EN
        exp_csum = 32'h66;
`else
        exp_csum = 32'h0;
`endif
        check_eq("copy_csum", checksum, exp_csum);

        // Fill of 4 words
        run_cmd(1'b1, 32'hDEADBEEF, 32'h40, 16'd4, 0, 0);
        $display("fill 0x40 n=4: latency %0d, writes %0d", lat, nwr);
        check_eq("fill_lat", lat, 5);
        check_eq("fill_nwr", nwr, 4);
        check_eq("fill_span", last_we - first_we + 1, 4);
        @(negedge clk);
        for (int k = 0; k < 4; k++) check_eq("fill_mem", mem[16 + k], 32'hDEADBEEF);
`ifdef MEM_BLOCK_MOVER_CHECKSUM_EN
        exp_csum = 32'h7AB6FBBC;
`else
        exp_csum = 32'h0;
`endif
        check_eq("fill_csum", checksum, exp_csum);

        // count = 0
        run_cmd(1'b1, 32'h12345678, 32'h80, 16'd0, 0, 0);
        $display("fill 0x80 n=0: latency %0d, writes %0d", lat, nwr);
        check_eq("zero_lat", lat, 1);
        check_eq("zero_nwr", nwr, 0);
        @(negedge clk);
        check_eq("zero_m80", mem[8'h20], 32'hA000_0020);
        check_eq("zero_csum", checksum, 32'h0);

        // Misaligned destination, with an ignored start while busy
        run_cmd(1'b1, 32'h5A5A5A5A, 32'h203, 16'd2, 1, 0);
        $display("fill 0x203 n=2 + stray start: latency %0d, writes %0d", lat, nwr);
        check_eq("mis_lat", lat, 3);
        check_eq("mis_nwr", nwr, 2);
        check_eq("mis_addr0", wa.size() > 0 ? wa[0] : 32'hFFFF_FFFF, 32'h200);
        @(negedge clk);
        check_eq("mis_m200", mem[8'h80], 32'h5A5A5A5A);
        check_eq("mis_m204", mem[8'h81], 32'h5A5A5A5A);
        check_eq("mis_m208", mem[8'h82], 32'h33);
        check_eq("mis_idle_busy", {31'h0, busy}, 32'h0);

        // Reset in the 5th cycle of an 8-word copy
        run_cmd(1'b0, 32'h100, 32'h300, 16'd8, 0, 5);
        $display("copy n=8 reset at cycle 5: done seen at %0d, writes %0d", lat, nwr);
        check_eq("rst_nodone", lat, 0);
        check_eq("rst_nwr", nwr, 2);
        check_eq("rst_m300", mem[8'hC0], 32'h11);
        check_eq("rst_m304", mem[8'hC1], 32'h22);
        check_eq("rst_m308", mem[8'hC2], 32'hA000_00C2);

        // Overlapping forward copy
        preload(32'h100, 32'hAAAA0001);
        preload(32'h104, 32'hBBBB0002);
        run_cmd(1'b0, 32'h100, 32'h104, 16'd2, 0, 0);
        $display("overlap copy n=2: latency %0d, writes %0d", lat, nwr);
        check_eq("ovl_lat", lat, 5);
        @(negedge clk);
        check_eq("ovl_m104", mem[8'h41], 32'hAAAA0001);
        check_eq("ovl_m108", mem[8'h42], 32'hAAAA0001);

        // Address wrap
        run_cmd(1'b1, 32'hCAFEF00D, 32'hFFFFFFFC, 16'd2, 0, 0);
        $display("fill wrap n=2: latency %0d, writes %0d", lat, nwr);
        check_eq("wrap_lat", lat, 3);
        check_eq("wrap_nwr", nwr, 2);
        check_eq("wrap_addr0", wa.size() > 0 ? wa[0] : 32'h1, 32'hFFFFFFFC);
        check_eq("wrap_addr1", wa.size() > 1 ? wa[1] : 32'h1, 32'h0);
        @(negedge clk);
        check_eq("wrap_m0", mem[0], 32'hCAFEF00D);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
